// File: rtl/twos_comp_serial_pkg.sv
// Shared types for the bit-serial two's complementer: the operation encoding
// and the controller states. Nothing here depends on WIDTH.
package twos_comp_pkg;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        ONES = 2'b01,
        NEG  = 2'b10,
        ABS  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/twos_comp_serial_if.sv
// Operand/result handshake bundle. The master drives operands and accepts
// results; the slave is the serial complementer.
interface twos_comp_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             ovf;

    modport master (
        output in_valid, din, mode, out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din, mode, out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/twos_comp_serial_neg_cell.sv
// One-bit serial negation cell. Negation LSB-first copies bits up to and
// including the first 1, then inverts the rest; seen_one remembers whether
// that first 1 has already gone past.
module serial_neg_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic neg_en,
    input  logic inv,
    input  logic b,
    output logic out_bit
);
    logic seen_one;

    // Track the first 1 bit of the operand while a negation is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_one <= 1'b0;
        end else if (clr) begin
            seen_one <= 1'b0;
        end else if (en && neg_en) begin
            seen_one <= seen_one | b;
        end
    end

    // Select pass-through, plain inversion or serial negation for this bit.
    always_comb begin
        out_bit = b;
        if (inv) begin
            out_bit = ~b;
        end else if (neg_en) begin
            out_bit = seen_one ? ~b : b;
        end
    end
endmodule

// File: rtl/twos_comp_serial.sv
// Bit-serial two's complementer: captures an operand over a valid/ready
// handshake, processes it LSB-first one bit per clock, and holds the result
// with an overflow flag until the sink accepts it.
module twos_comp_serial
    import twos_comp_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    twos_comp_serial_if.slave  bus
);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_e             state;
    state_e             state_next;
    logic               capture;
    logic               shift_en;
    logic               last_bit;

    logic [WIDTH-1:0]   operand;
    mode_e              mode_q;
    logic               neg_en_q;
    logic               ovf_pend;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   res_sh;
    logic [WIDTH-1:0]   dout_q;
    logic               ovf_q;

    mode_e              mode_in;
    logic               neg_en_in;
    logic               out_bit;

    assign mode_in   = mode_e'(bus.mode);
    assign neg_en_in = (mode_in == NEG) || ((mode_in == ABS) && bus.din[WIDTH-1]);
    assign last_bit  = (cnt == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, bit shifting and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand  <= '0;
            mode_q   <= PASS;
            neg_en_q <= 1'b0;
            ovf_pend <= 1'b0;
            cnt      <= '0;
            res_sh   <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else if (capture) begin
            operand  <= bus.din;
            mode_q   <= mode_in;
            neg_en_q <= neg_en_in;
            ovf_pend <= neg_en_in && (bus.din == MIN_VAL);
            cnt      <= '0;
        end else if (shift_en) begin
            operand <= operand >> 1;
            res_sh  <= {out_bit, res_sh[WIDTH-1:1]};
            cnt     <= cnt + CNT_W'(1);
            // dout/ovf only move on the edge that leaves SHIFT.
            if (last_bit) begin
                dout_q <= {out_bit, res_sh[WIDTH-1:1]};
                ovf_q  <= ovf_pend;
            end
        end
    end

    serial_neg_cell u_neg_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (capture),
        .en      (shift_en),
        .neg_en  (neg_en_q),
        .inv     (mode_q == ONES),
        .b       (operand[0]),
        .out_bit (out_bit)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_twos_comp_serial.sv
// Bench for the serial two's complementer at WIDTH=8: a vector table, a few
// random operands against a reference model, backpressure and reset abort.
module tb_twos_comp_serial;
    localparam int W = 8;

    typedef struct {
        logic [7:0] din;
        logic [1:0] mode;
        logic [7:0] exp_dout;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t vecs[12];

    twos_comp_serial_if #(.WIDTH(W)) bus ();

    twos_comp_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic [1:0] m);
        exp_t e;
        logic ng;
        ng = (m == 2'b10) || (m == 2'b11 && d[7]);
        case (m)
            2'b00:   e.dout = d;
            2'b01:   e.dout = ~d;
            default: e.dout = ng ? 8'(-d) : d;
        endcase
        e.ovf = ng && (d == 8'h80);
        return e;
    endfunction

    // Drive one operand, push its expectation, wait for the result and check it.
    task automatic run_op(input logic [7:0] d, input logic [1:0] m,
                          input logic [7:0] ed, input logic eo);
        int   n;
        exp_t e;
        exp_t got;
        @(negedge clk);
        bus.din = d; bus.mode = m; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        e.dout = ed; e.ovf = eo;
        sb.push_back(e);
        #1 bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!bus.out_valid && n < 40);
        check("latency", n, W);
        if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
            got = sb.pop_front();
            check("dout", bus.dout, got.dout);
            check("ovf", bus.ovf, got.ovf);
            $display("op din=%02h mode=%0d dout=%02h ovf=%0b exp=%02h/%0b",
                     d, m, bus.dout, bus.ovf, got.dout, got.ovf);
        end else begin
            check("result_handshake", {bus.out_valid, 31'(sb.size())}, {1'b1, 31'd1});
        end
        @(posedge clk);
        #1 check("back_to_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    endtask

    initial begin
        logic [7:0] hold_dout;
        logic       hold_ovf;
        exp_t       e;
        checks = 0;
        errors = 0;

        vecs[0]  = '{8'hBB, 2'b10, 8'h45, 1'b0};
        vecs[1]  = '{8'hBB, 2'b01, 8'h44, 1'b0};
        vecs[2]  = '{8'hBB, 2'b00, 8'hBB, 1'b0};
        vecs[3]  = '{8'hBB, 2'b11, 8'h45, 1'b0};
        vecs[4]  = '{8'h45, 2'b11, 8'h45, 1'b0};
        vecs[5]  = '{8'h80, 2'b11, 8'h80, 1'b1};
        vecs[6]  = '{8'h00, 2'b10, 8'h00, 1'b0};
        vecs[7]  = '{8'h01, 2'b10, 8'hFF, 1'b0};
        vecs[8]  = '{8'h80, 2'b10, 8'h80, 1'b1};
        vecs[9]  = '{8'h80, 2'b01, 8'h7F, 1'b0};
        vecs[10] = '{8'h80, 2'b00, 8'h80, 1'b0};
        vecs[11] = '{8'h7F, 2'b10, 8'h81, 1'b0};

        bus.in_valid = 1'b0; bus.din = '0; bus.mode = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", {bus.in_ready, bus.out_valid, bus.dout, bus.ovf}, {1'b1, 1'b0, 8'h00, 1'b0});
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].din, vecs[i].mode, vecs[i].exp_dout, vecs[i].exp_ovf);
        end

        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            logic [1:0] m;
            d = 8'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 3));
            e = model(d, m);
            run_op(d, m, e.dout, e.ovf);
        end

        // Backpressure: hold the result for 5 cycles with a stray in_valid pulse.
        @(negedge clk);
        bus.din = 8'hBB; bus.mode = 2'b10; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1 check("bp_valid", bus.out_valid, 1'b1);
        hold_dout = bus.dout;
        hold_ovf  = bus.ovf;
        check("bp_dout", hold_dout, 8'h45);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.din = 8'h01; bus.mode = 2'b00; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1 check("bp_hold", {bus.out_valid, bus.in_ready, bus.dout, bus.ovf},
                     {1'b1, 1'b0, 8'h45, 1'b0});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 check("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);
        repeat (W + 2) @(posedge clk);
        #1 check("bp_no_stray_op", {bus.out_valid, bus.dout}, {1'b0, 8'h45});
        $display("backpressure dout=%02h ovf=%0b", hold_dout, hold_ovf);

        // Reset mid-SHIFT: abort at bit 4 of a NEG.
        @(negedge clk);
        bus.din = 8'h12; bus.mode = 2'b10; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_abort", {bus.in_ready, bus.out_valid, bus.dout, bus.ovf}, {1'b1, 1'b0, 8'h00, 1'b0});
        sb.delete();
        $display("reset abort in_ready=%0b out_valid=%0b dout=%02h", bus.in_ready, bus.out_valid, bus.dout);
        @(negedge clk) rst_n = 1'b1;
        run_op(8'h7F, 2'b10, 8'h81, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/twos_comp_serial.md
# twos_comp_serial

Bit-serial, parametrised successor to the combinational 8-bit two's complementer. It accepts a WIDTH-bit operand and a mode over a valid/ready handshake, then processes the operand LSB-first, one bit per clock. The result is presented on a second valid/ready handshake with an overflow flag. It sits in the lab datapath as a low-area arithmetic unit between an operand source and a result sink.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, do not override.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand and mode are valid.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- din  in  WIDTH  operand.
- mode  in  2  operation, encoded as follows:
  - 00 PASS: result = din.
  - 01 ONES: result = ~din.
  - 10 NEG: result = ~din + 1.
  - 11 ABS: result = |din| (signed).
- out_valid  out  1  result is valid.
- out_ready  in  1  sink accepts the result.
- dout  out  WIDTH  result.
- ovf  out  1  NEG or ABS was applied to the most-negative value (1 followed by WIDTH-1 zeros).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, the block captures din into an operand shift register and mode into a mode register.
  - neg_en = (mode==NEG) or (mode==ABS and din[WIDTH-1]).
  - ovf = neg_en and din == {1'b1,{WIDTH-1{1'b0}}}.
  - seen_one is cleared, the counter is cleared, and the FSM moves to SHIFT.
- SHIFT: each cycle, b = operand LSB.
  - PASS: out bit = b.
  - ONES: out bit = ~b.
  - NEG, and ABS with neg_en: out bit = seen_one ? ~b : b, then seen_one |= b.
  - ABS without neg_en: out bit = b.
  - The operand shifts right. The out bit shifts into the result register from the MSB side.
  - The counter increments. When the counter is at WIDTH-1, the FSM moves to DONE.
- DONE:
  - out_valid = 1; dout and ovf are held stable.
  - On out_ready, the FSM moves to IDLE.
- No arithmetic wider than one bit is performed. The result wraps modulo 2^WIDTH, so NEG of the most-negative value returns the same value with ovf = 1. NEG of 0 returns 0 with ovf = 0.
- in_valid outside IDLE is ignored. The source must hold the operand until in_ready.

## Timing
- Reset (async assert, release synchronised by the system):
  - State = IDLE, in_ready = 1.
  - out_valid = 0, dout = 0, ovf = 0.
  - Counter, seen_one, operand and mode registers = 0.
- Latency: operand accepted at edge k; out_valid is high after edge k+WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles. There is no overlap between result hold and the next capture.
- dout and ovf change only on the edge that leaves SHIFT, and hold through DONE regardless of out_ready.
- in_ready and out_valid are decoded from registered state only. There are no combinational paths from any input to any output.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. Any pending result is lost and all outputs return to reset values.

## Structure
- twos_comp_pkg holds:
  - mode_e enum: PASS, ONES, NEG, ABS.
  - state_e enum: IDLE, SHIFT, DONE.
  - No WIDTH-dependent constants.
- Sub-module serial_neg_cell:
  - Contains the seen_one flop and the bit-select logic.
  - Ports: clk, rst_n, clr, en, neg_en, inv, b, out_bit.
  - Instantiated once.
- Top level contains the FSM, counter, operand/result shift registers and handshake logic.

## Test plan
All scenarios use WIDTH=8.
- Accept and latency: din=8'b10111011, mode=NEG, out_ready=1 → dout=8'b01000101, ovf=0, with out_valid exactly 8 cycles after acceptance.
- ONES: din=8'hBB → dout=8'h44. PASS: din=8'hBB → dout=8'hBB.
- ABS: din=8'hBB → 8'h45. ABS: din=8'h45 → 8'h45. ABS: din=8'h80 → 8'h80, ovf=1.
- NEG edge cases: din=8'h00 → 8'h00, ovf=0. din=8'h01 → 8'hFF. din=8'h80 → 8'h80, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, dout and ovf are stable and in_ready=0. A pulsed in_valid during this time is ignored. Raising out_ready → IDLE on the next cycle.
- Reset mid-operation: assert rst_n=0 at bit 4 of a NEG → all outputs return to reset values asynchronously. After release, a new operand (8'h7F, NEG) produces 8'h81.
